// File: rtl/subst_cipher_prog_if.sv
// Handshake bundle for the programmable substitution cipher: request, result and table-write channels.
// Channel rule: a transfer happens on a rising edge where valid (or wr_en) and ready are both high.
interface subst_cipher_prog_if #(
    parameter int DIN_W  = 3,
    parameter int DOUT_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [DOUT_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DOUT_W-1:0] out_data;
    logic              out_miss;
    logic              wr_en;
    logic [DIN_W-1:0]  wr_addr;
    logic [DOUT_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output in_valid, in_mode, in_data, out_ready, wr_en, wr_addr, wr_data,
        input  in_ready, out_valid, out_data, out_miss, wr_ready
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready, wr_en, wr_addr, wr_data,
        output in_ready, out_valid, out_data, out_miss, wr_ready
    );
endinterface

// File: rtl/subst_cipher_prog.sv
// Programmable substitution cipher: table lookup for encrypt, one-entry-per-cycle
// reverse scan for decrypt, run-time writable table reloaded with key defaults on reset.
module subst_cipher_prog #(
    parameter int DIN_W   = 3,
    parameter int DOUT_W  = 5,
    parameter int KEY_MUL = 5,
    parameter int KEY_ADD = 3
) (
    input  logic               CLK,
    input  logic               nRST,
    subst_cipher_prog_if.slave bus,
    output logic [1:0]         fsm_state
);
    localparam int DEPTH = 2 ** DIN_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    logic [DOUT_W-1:0] tbl [DEPTH];
    logic [DOUT_W-1:0] key;
    logic [DIN_W-1:0]  idx;
    logic              out_valid_q;
    logic [DOUT_W-1:0] out_data_q;
    logic              out_miss_q;
    logic              accept;

    // Writes win over requests in IDLE; both channels are closed while busy.
    assign bus.wr_ready  = (state == IDLE);
    assign bus.in_ready  = (state == IDLE) && !bus.wr_en;
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_miss  = out_miss_q;
    assign fsm_state     = state;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_miss_q  <= 1'b0;
            idx         <= '0;
            key         <= '0;
            // Truncation to DOUT_W bits gives the modulo 2**DOUT_W default entries.
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= DOUT_W'(i * KEY_MUL + KEY_ADD);
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wr_en) begin
                        tbl[bus.wr_addr] <= bus.wr_data;
                    end else if (accept) begin
                        if (!bus.in_mode) begin
                            out_data_q  <= tbl[bus.in_data[DIN_W-1:0]];
                            out_miss_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            key   <= bus.in_data;
                            idx   <= '0;
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    // Ascending scan, so duplicate entries resolve to the lowest index.
                    if (tbl[idx] == key) begin
                        out_data_q  <= DOUT_W'(idx);
                        out_miss_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= HOLD;
                    end else if (idx == DIN_W'(DEPTH - 1)) begin
                        out_data_q  <= '0;
                        out_miss_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        idx <= idx + DIN_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
